win_judge_ctrl: RTL and testbench
=================================

Name: win_judge_ctrl

Overview:
- Sequencer that decides whether the stone just placed wins the game.
- Accepts one move at a time over a valid/ready handshake and snapshots the mover's 225-bit stone board.
- Walks four directions through one shared combinational five-in-a-row checker, one direction per cycle, exiting early on the first hit.
- Sits between the move-input/AI controller and the game-state/display logic.

Parameters:
- BOARD_N, 15, board side length; cell index = row*BOARD_N + col.
- WIN_LEN, 5, number of consecutive stones required to win.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- move_valid  input  1  move request.
- move_ready  output  1  block can accept a move; high only in IDLE.
- move_row  input  4  row of placed stone.
- move_col  input  4  column of placed stone.
- move_player  input  1  0 = black, 1 = white.
- board_black  input  225  black stone map; bit idx set = stone present.
- board_white  input  225  white stone map.
- game_clr  input  1  new-game pulse; clears the draw move counter.
- busy  output  1  high in CHECK and DONE.
- result_valid  output  1  one-cycle pulse carrying the verdict.
- win  output  1  mover has WIN_LEN in a row through (row, col).
- winner  output  1  copy of the captured move_player.
- win_dir  output  2  direction that hit: 0 = horizontal, 1 = vertical, 2 = upper-left→lower-right, 3 = upper-right→lower-left.
- coord_err  output  1  row or col is >= BOARD_N; check skipped.
- draw  output  1  board full without a win; 0 unless DRAW_DETECT_EN.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0 except move_ready = 1. State = IDLE, dir_cnt = 0, snapshot register = 0.
- IDLE
  - move_ready = 1.
  - Handshake at cycle T (move_valid && move_ready): capture row, col and player.
  - Capture the board selected by move_player (board_white if 1, else board_black) into a 225-bit snapshot.
  - Go to CHECK with dir_cnt = 0; move_ready drops at T+1.
- CHECK
  - Each cycle, the sub-checker evaluates the snapshot at (row, col) in direction dir_cnt.
  - hit = some WIN_LEN-cell window containing (row, col), lying fully on board along that direction, has every bit set.
  - Windows never wrap across row edges.
  - On hit: latch win = 1 and win_dir = dir_cnt, go to DONE.
  - On miss with dir_cnt = 3: go to DONE with win = 0 and win_dir = 0.
  - Otherwise increment dir_cnt.
- Coordinate error: on capture of an invalid coordinate, go straight to DONE with coord_err = 1 and win = 0.
- DONE
  - result_valid = 1 for exactly one cycle; win, winner, win_dir, coord_err and draw hold their values for that cycle only and are 0 otherwise.
  - Next state is IDLE.
- Latency: a hit in direction k gives result_valid at T+2+k. No win gives T+5. coord_err gives T+2.
- Inputs are ignored between capture and DONE: board changes after T do not affect the verdict. move_valid while busy is not accepted; the requester holds it.
- Back-to-back: the next move is accepted no earlier than the cycle after DONE (a result every ≥3 cycles).
- rst mid-operation: abort in the same edge, no result_valid pulse, return to reset values.
- game_clr concurrent with a handshake: clear the counter first, then count the new move.

Optional Feature:
- Macro: WIN_JUDGE_DRAW_DETECT_EN.
- Enabled
  - A 8-bit move counter increments on each accepted move with valid coordinates.
  - It saturates at BOARD_N*BOARD_N and is cleared by rst or game_clr.
  - In DONE, draw = 1 when win = 0 and the counter (including this move) equals BOARD_N*BOARD_N.
- Disabled: no counter, draw tied to 0, game_clr unused.

Decomposition:
- Package gobang_pkg:
  - constants BOARD_N = 15, CELLS = 225, WIN_LEN = 5;
  - direction encodings DIR_H / DIR_V / DIR_DIAG / DIR_ANTI;
  - player encodings P_BLACK / P_WHITE;
  - state encoding IDLE / CHECK / DONE.
- Sub-module line_five_check: purely combinational.
  - Inputs: board[224:0], row, col, dir[1:0]. Output: hit.
  - Instantiated once and shared across directions by dir_cnt.

Test Plan:
- Black stones at (7,3)..(7,7), move (7,7) black → result_valid at T+2, win = 1, win_dir = 0, winner = 0.
- White stones at (0,0),(1,1),(2,2),(3,3),(4,4), move (4,4) white → result_valid at T+4, win = 1, win_dir = 2, winner = 1.
- Black stones at (14,10)..(14,14) but move_player = 1 at (14,14) → result_valid at T+5, win = 0 (wrong board selected).
- Row-edge wrap: black at (0,12),(0,13),(0,14),(1,0),(1,1), move (1,1) → win = 0 (no wrap-around hit).
- Move (15,3) → result_valid at T+2, coord_err = 1, win = 0.
- rst asserted at T+2 during CHECK → no result_valid; move_ready = 1 at the following cycle.
- With WIN_JUDGE_DRAW_DETECT_EN, 225 accepted non-winning moves → 225th result has draw = 1; after game_clr, the next move gives draw = 0.

Source files
------------

// File: rtl/win_judge_ctrl_pkg.sv
// Shared gobang constants, encodings and coordinate helper used by the
// win-judge sequencer, its interface and the five-in-a-row checker.
package gobang_pkg;

    localparam int BOARD_N = 15;
    localparam int CELLS   = BOARD_N * BOARD_N;
    localparam int WIN_LEN = 5;

    typedef enum logic [1:0] {
        DIR_H    = 2'd0,
        DIR_V    = 2'd1,
        DIR_DIAG = 2'd2,
        DIR_ANTI = 2'd3
    } dir_e;

    typedef enum logic {
        P_BLACK = 1'b0,
        P_WHITE = 1'b1
    } player_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic coord_ok(input logic [3:0] row, input logic [3:0] col);
        return (row < 4'(BOARD_N)) && (col < 4'(BOARD_N));
    endfunction

endpackage

// File: rtl/win_judge_ctrl_if.sv
// Move request / verdict bundle between the move source and the win judge.
// master = move source + result consumer, slave = win_judge_ctrl.
interface win_judge_ctrl_if;
    import gobang_pkg::*;

    logic               move_valid;
    logic               move_ready;
    logic [3:0]         move_row;
    logic [3:0]         move_col;
    logic               move_player;
    logic [CELLS-1:0]   board_black;
    logic [CELLS-1:0]   board_white;
    logic               game_clr;
    logic               busy;
    logic               result_valid;
    logic               win;
    logic               winner;
    logic [1:0]         win_dir;
    logic               coord_err;
    logic               draw;

    modport master (
        output move_valid, move_row, move_col, move_player,
        output board_black, board_white, game_clr,
        input  move_ready, busy, result_valid, win, winner,
        input  win_dir, coord_err, draw
    );

    modport slave (
        input  move_valid, move_row, move_col, move_player,
        input  board_black, board_white, game_clr,
        output move_ready, busy, result_valid, win, winner,
        output win_dir, coord_err, draw
    );

endinterface

// File: rtl/win_judge_ctrl_line_five_check.sv
// Combinational five-in-a-row test through (row, col) along one direction.
// Every window position that contains the cell is tried; off-board cells fail.
module line_five_check
    import gobang_pkg::*;
(
    input  logic [CELLS-1:0] board,
    input  logic [3:0]       row,
    input  logic [3:0]       col,
    input  logic [1:0]       dir,
    output logic             hit
);

    int         dr_s;
    int         dc_s;
    int         r_s;
    int         c_s;
    logic       win_ok_s;
    logic [7:0] cell_idx_s;

    // Scan all WIN_LEN windows; row/col bounds are checked separately so no window wraps.
    always_comb begin
        hit        = 1'b0;
        dr_s       = 0;
        dc_s       = 0;
        r_s        = 0;
        c_s        = 0;
        win_ok_s   = 1'b0;
        cell_idx_s = 8'd0;
        case (dir_e'(dir))
            DIR_H:    begin dr_s = 0; dc_s = 1;  end
            DIR_V:    begin dr_s = 1; dc_s = 0;  end
            DIR_DIAG: begin dr_s = 1; dc_s = 1;  end
            DIR_ANTI: begin dr_s = 1; dc_s = -1; end
            default:  begin dr_s = 0; dc_s = 1;  end
        endcase
        for (int s = 0; s < WIN_LEN; s++) begin
            win_ok_s = 1'b1;
            for (int k = 0; k < WIN_LEN; k++) begin
                r_s = int'(row) + (k - s) * dr_s;
                c_s = int'(col) + (k - s) * dc_s;
                if ((r_s < 0) || (r_s >= BOARD_N) || (c_s < 0) || (c_s >= BOARD_N)) begin
                    win_ok_s = 1'b0;
                end else begin
                    cell_idx_s = 8'(r_s * BOARD_N + c_s);
                    if (!board[cell_idx_s]) begin
                        win_ok_s = 1'b0;
                    end else begin
                        win_ok_s = win_ok_s;
                    end
                end
            end
            if (win_ok_s) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
    end

endmodule

// File: rtl/win_judge_ctrl.sv
// Win judge: snapshots the mover's board and walks four directions through
// one shared line_five_check. Optional draw counter: WIN_JUDGE_DRAW_DETECT_EN.
module win_judge_ctrl
    import gobang_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    win_judge_ctrl_if.slave  jif
);

    state_e           state_q, state_d;
    logic [1:0]       dir_cnt_q, dir_cnt_d;
    logic [3:0]       row_q, row_d;
    logic [3:0]       col_q, col_d;
    logic             player_q, player_d;
    logic             bad_q, bad_d;
    logic [CELLS-1:0] snap_q, snap_d;

    logic             move_ready_q, move_ready_d;
    logic             busy_q, busy_d;
    logic             result_valid_q, result_valid_d;
    logic             win_q, win_d;
    logic             winner_q, winner_d;
    logic [1:0]       win_dir_q, win_dir_d;
    logic             coord_err_q, coord_err_d;
    logic             draw_q, draw_d;

    logic             accept_s;
    logic             hit_s;
    logic             board_full_s;

    assign accept_s = jif.move_valid && move_ready_q;

    line_five_check u_line_five_check (
        .board (snap_q),
        .row   (row_q),
        .col   (col_q),
        .dir   (dir_cnt_q),
        .hit   (hit_s)
    );

`ifdef WIN_JUDGE_DRAW_DETECT_EN
    logic [7:0] move_cnt_q, move_cnt_d;
    logic [7:0] cnt_base_s;

    // game_clr wins over a concurrent move so the new move is counted from zero.
    always_comb begin
        cnt_base_s = jif.game_clr ? 8'd0 : move_cnt_q;
        if (accept_s && coord_ok(jif.move_row, jif.move_col) && (cnt_base_s < 8'(CELLS))) begin
            move_cnt_d = cnt_base_s + 8'd1;
        end else begin
            move_cnt_d = cnt_base_s;
        end
    end

    // Move counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            move_cnt_q <= 8'd0;
        end else begin
            move_cnt_q <= move_cnt_d;
        end
    end

    assign board_full_s = (move_cnt_q == 8'(CELLS));
`else
    assign board_full_s = 1'b0;
`endif

    // Next-state and next-output logic; verdict outputs are nonzero only in DONE.
    always_comb begin
        state_d        = state_q;
        dir_cnt_d      = dir_cnt_q;
        row_d          = row_q;
        col_d          = col_q;
        player_d       = player_q;
        bad_d          = bad_q;
        snap_d         = snap_q;
        result_valid_d = 1'b0;
        win_d          = 1'b0;
        winner_d       = 1'b0;
        win_dir_d      = 2'd0;
        coord_err_d    = 1'b0;
        draw_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    row_d     = jif.move_row;
                    col_d     = jif.move_col;
                    player_d  = jif.move_player;
                    bad_d     = !coord_ok(jif.move_row, jif.move_col);
                    snap_d    = (jif.move_player == P_WHITE) ? jif.board_white : jif.board_black;
                    dir_cnt_d = 2'd0;
                    state_d   = CHECK;
                end else begin
                    state_d   = IDLE;
                end
            end
            CHECK: begin
                // A bad coordinate still spends one CHECK cycle, matching a direction-0 hit.
                if (bad_q) begin
                    state_d        = DONE;
                    result_valid_d = 1'b1;
                    coord_err_d    = 1'b1;
                    winner_d       = player_q;
                end else if (hit_s) begin
                    state_d        = DONE;
                    result_valid_d = 1'b1;
                    win_d          = 1'b1;
                    win_dir_d      = dir_cnt_q;
                    winner_d       = player_q;
                end else if (dir_cnt_q == 2'd3) begin
                    state_d        = DONE;
                    result_valid_d = 1'b1;
                    winner_d       = player_q;
                    draw_d         = board_full_s;
                end else begin
                    dir_cnt_d      = dir_cnt_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        move_ready_d = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
    end

    // State, capture and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            dir_cnt_q      <= 2'd0;
            row_q          <= 4'd0;
            col_q          <= 4'd0;
            player_q       <= 1'b0;
            bad_q          <= 1'b0;
            snap_q         <= '0;
            move_ready_q   <= 1'b1;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            win_q          <= 1'b0;
            winner_q       <= 1'b0;
            win_dir_q      <= 2'd0;
            coord_err_q    <= 1'b0;
            draw_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            dir_cnt_q      <= dir_cnt_d;
            row_q          <= row_d;
            col_q          <= col_d;
            player_q       <= player_d;
            bad_q          <= bad_d;
            snap_q         <= snap_d;
            move_ready_q   <= move_ready_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            win_q          <= win_d;
            winner_q       <= winner_d;
            win_dir_q      <= win_dir_d;
            coord_err_q    <= coord_err_d;
            draw_q         <= draw_d;
        end
    end

    assign jif.move_ready   = move_ready_q;
    assign jif.busy         = busy_q;
    assign jif.result_valid = result_valid_q;
    assign jif.win          = win_q;
    assign jif.winner       = winner_q;
    assign jif.win_dir      = win_dir_q;
    assign jif.coord_err    = coord_err_q;
    assign jif.draw         = draw_q;

endmodule

// File: tb/tb_win_judge_ctrl.sv
// Scoreboard bench for win_judge_ctrl: directed moves push expected verdicts,
// a negedge monitor pops and compares whenever result_valid is seen.
module tb_win_judge_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    win_judge_ctrl_if jif ();

    win_judge_ctrl dut (
        .clk (clk),
        .rst (rst),
        .jif (jif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       win;
        logic       winner;
        logic [1:0] dir;
        logic       cerr;
        logic       draw;
        int         lat;
        int         hs;
    } exp_t;

    exp_t q[$];
    exp_t e;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [224:0] put(input logic [224:0] b, input int r, input int c);
        logic [224:0] one;
        one = 225'd1;
        return b | (one << (r * 15 + c));
    endfunction

    // Monitor: compare each verdict against the oldest expectation; outputs idle otherwise.
    always @(negedge clk) begin
        if (cyc >= 2) begin
            if (jif.result_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("win",       32'(jif.win),       32'(e.win));
                    chk("winner",    32'(jif.winner),    32'(e.winner));
                    chk("win_dir",   32'(jif.win_dir),   32'(e.dir));
                    chk("coord_err", 32'(jif.coord_err), 32'(e.cerr));
                    chk("draw",      32'(jif.draw),      32'(e.draw));
                    chk("latency",   32'(cyc - e.hs + 1), 32'(e.lat));
                end
            end else begin
                chk("quiet_outputs",
                    32'({jif.win, jif.winner, jif.win_dir, jif.coord_err, jif.draw}), 32'd0);
            end
        end
    end

    task automatic send(input int r, input int c, input logic p,
                        input logic [224:0] bb, input logic [224:0] bw,
                        input bit exp_res, input logic e_win, input logic [1:0] e_dir,
                        input logic e_cerr, input logic e_draw, input int e_lat);
        int   n;
        exp_t x;
        jif.move_row    = 4'(r);
        jif.move_col    = 4'(c);
        jif.move_player = p;
        jif.board_black = bb;
        jif.board_white = bw;
        jif.move_valid  = 1'b1;
        n = 0;
        while (!jif.move_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("handshake_timeout", 32'd0, 32'd1);
            jif.move_valid = 1'b0;
            return;
        end
        if (exp_res) begin
            x.win = e_win; x.winner = p; x.dir = e_dir; x.cerr = e_cerr;
            x.draw = e_draw; x.lat = e_lat; x.hs = cyc + 1;
            q.push_back(x);
        end
        @(posedge clk);
        #1;
        jif.move_valid  = 1'b0;
        jif.board_black = '1;
        jif.board_white = '1;
        @(negedge clk);
        chk("ready_drop", 32'(jif.move_ready), 32'd0);
        chk("busy_high",  32'(jif.busy),       32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [224:0] b0, b1, b2, z;
        z = '0;
        jif.move_valid  = 1'b0;
        jif.move_row    = 4'd0;
        jif.move_col    = 4'd0;
        jif.move_player = 1'b0;
        jif.board_black = '0;
        jif.board_white = '0;
        jif.game_clr    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_move_ready",   32'(jif.move_ready),   32'd1);
        chk("rst_busy",         32'(jif.busy),         32'd0);
        chk("rst_result_valid", 32'(jif.result_valid), 32'd0);

        // horizontal black (7,3)..(7,7), move (7,7)
        b0 = z; for (int k = 0; k < 5; k++) b0 = put(b0, 7, 3 + k);
        send(7, 7, 1'b0, b0, z, 1, 1'b1, 2'd0, 1'b0, 1'b0, 2);

        // white diagonal; black also has a row through (4,4) but must be ignored
        b0 = z; b1 = z;
        for (int k = 0; k < 5; k++) begin b1 = put(b1, k, k); b0 = put(b0, 4, k); end
        send(4, 4, 1'b1, b0, b1, 1, 1'b1, 2'd2, 1'b0, 1'b0, 4);

        // black row at bottom-right but white is the mover
        b0 = z; for (int k = 0; k < 5; k++) b0 = put(b0, 14, 10 + k);
        send(14, 14, 1'b1, b0, z, 1, 1'b0, 2'd0, 1'b0, 1'b0, 5);
        // same board as black: right-edge hit
        send(14, 14, 1'b0, b0, z, 1, 1'b1, 2'd0, 1'b0, 1'b0, 2);

        // row wrap must not count
        b0 = put(put(put(put(put(z, 0, 12), 0, 13), 0, 14), 1, 0), 1, 1);
        send(1, 1, 1'b0, b0, z, 1, 1'b0, 2'd0, 1'b0, 1'b0, 5);

        // invalid coordinates
        send(15, 3, 1'b0, '1, '1, 1, 1'b0, 2'd0, 1'b1, 1'b0, 2);
        send(3, 15, 1'b0, '1, '1, 1, 1'b0, 2'd0, 1'b1, 1'b0, 2);

        // vertical white, move in the middle of the run
        b1 = z; for (int k = 0; k < 5; k++) b1 = put(b1, 10 + k, 2);
        send(12, 2, 1'b1, z, b1, 1, 1'b1, 2'd1, 1'b0, 1'b0, 3);

        // anti-diagonal black through (4,4)
        b0 = z; for (int k = 0; k < 5; k++) b0 = put(b0, 2 + k, 6 - k);
        send(4, 4, 1'b0, b0, z, 1, 1'b1, 2'd3, 1'b0, 1'b0, 5);

        // only four in a row
        b0 = z; for (int k = 0; k < 4; k++) b0 = put(b0, 7, k);
        send(7, 3, 1'b0, b0, z, 1, 1'b0, 2'd0, 1'b0, 1'b0, 5);

        // top-left corner row
        b2 = z; for (int k = 0; k < 5; k++) b2 = put(b2, 0, k);
        send(0, 0, 1'b0, b2, z, 1, 1'b1, 2'd0, 1'b0, 1'b0, 2);

        // reset during CHECK: no verdict, ready again right after
        send(5, 5, 1'b0, z, z, 0, 1'b0, 2'd0, 1'b0, 1'b0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(jif.move_ready), 32'd1);
        chk("post_rst_busy",  32'(jif.busy),       32'd0);
        repeat (5) @(negedge clk);

        b0 = z; for (int k = 0; k < 5; k++) b0 = put(b0, 7, 3 + k);
        send(7, 5, 1'b0, b0, z, 1, 1'b1, 2'd0, 1'b0, 1'b0, 2);

`ifdef WIN_JUDGE_DRAW_DETECT_EN
        jif.game_clr = 1'b1;
        @(posedge clk);
        #1 jif.game_clr = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 225; i++) begin
            send(i % 15, i / 15, 1'b0, z, z, 1, 1'b0, 2'd0, 1'b0, (i == 224) ? 1'b1 : 1'b0, 5);
        end
        repeat (8) @(negedge clk);
        jif.game_clr = 1'b1;
        @(posedge clk);
        #1 jif.game_clr = 1'b0;
        @(negedge clk);
        send(3, 3, 1'b0, z, z, 1, 1'b0, 2'd0, 1'b0, 1'b0, 5);
`else
        send(3, 3, 1'b0, z, z, 1, 1'b0, 2'd0, 1'b0, 1'b0, 5);
`endif

        for (int n = 0; n < 20 && q.size() != 0; n++) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
